// File: rtl/csr_ro_bank_pkg.sv
// Shared constants and address helpers for the read-only status register bank.
package csr_ro_bank_pkg;

  // Flag bit positions, counted down from the top bit (bit DATA_W - ofs).
  localparam int VALID_OFS = 1;
  localparam int OVR_OFS   = 2;

  // The summary and version words sit directly after the last channel slot.
  localparam int SUM_SLOT_OFS = 0;
  localparam int VER_SLOT_OFS = 1;

  function automatic int chan_addr(input int base, input int i);
    return base + 4 * i;
  endfunction

endpackage

// File: rtl/csr_ro_chan.sv
// One status channel: captured value plus valid/overrun flags, cleared by bus reads.
module csr_ro_chan
  import csr_ro_bank_pkg::*;
#(
  parameter int FIELD_W = 12,
  parameter bit STICKY  = 1'b0,
  parameter bit RCLR    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd,
  input  logic               clr,
  input  logic [FIELD_W-1:0] din,
  output logic [FIELD_W-1:0] value,
  output logic               valid,
  output logic               ovr
);

  logic [FIELD_W-1:0] base;

  // A read on the same edge as an update drops the old value first, so a
  // sticky accumulation restarts from the fresh sample.
  assign base = (clr && RCLR) ? '0 : value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else if (upd) begin
      value <= STICKY ? (base | din) : din;
      valid <= 1'b1;
      ovr   <= clr ? 1'b0 : valid;
    end else if (clr) begin
      valid <= 1'b0;
      ovr   <= 1'b0;
      if (RCLR) value <= '0;
    end
  end

endmodule

// File: rtl/csr_ro_bank.sv
// Bank of read-only capture channels with summary/version words and a pending irq.
module csr_ro_bank
  import csr_ro_bank_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 32,
  parameter int          BASE_ADDR = 'h40,
  parameter int          NUM_CH    = 4,
  parameter int          FIELD_W   = 12,
  parameter bit          RCLR      = 1'b1,
  parameter bit          STICKY    = 1'b0,
  parameter logic [31:0] VERSION   = 32'h00020010
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         lb_waddr,
  input  logic [DATA_W-1:0]         lb_wdata,
  input  logic                      lb_wen,
  output logic                      lb_wready,
  input  logic [ADDR_W-1:0]         lb_raddr,
  input  logic                      lb_ren,
  output logic [DATA_W-1:0]         lb_rdata,
  output logic                      lb_rvalid,
  input  logic [NUM_CH*FIELD_W-1:0] ch_in,
  input  logic [NUM_CH-1:0]         ch_upd,
  output logic                      irq
);

  localparam logic [ADDR_W-1:0] SUM_ADDR =
    ADDR_W'(chan_addr(BASE_ADDR, NUM_CH + SUM_SLOT_OFS));
  localparam logic [ADDR_W-1:0] VER_ADDR =
    ADDR_W'(chan_addr(BASE_ADDR, NUM_CH + VER_SLOT_OFS));

  logic [NUM_CH-1:0][FIELD_W-1:0] value;
  logic [NUM_CH-1:0]              valid;
  logic [NUM_CH-1:0]              ovr;
  logic [NUM_CH-1:0]              clr;
  logic [DATA_W-1:0]              rd_word;

  // Writes are accepted and dropped; the bus only needs the handshake.
  logic unused_wr;
  assign unused_wr = ^{lb_waddr, lb_wdata, lb_wen};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    csr_ro_chan #(
      .FIELD_W (FIELD_W),
      .STICKY  (STICKY),
      .RCLR    (RCLR)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .upd   (ch_upd[i]),
      .clr   (clr[i]),
      .din   (ch_in[i*FIELD_W +: FIELD_W]),
      .value (value[i]),
      .valid (valid[i]),
      .ovr   (ovr[i])
    );
  end

  always_comb begin
    rd_word = '0;
    clr     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lb_raddr == ADDR_W'(chan_addr(BASE_ADDR, i))) begin
        rd_word[FIELD_W-1:0]      = value[i];
        rd_word[DATA_W-VALID_OFS] = valid[i];
        rd_word[DATA_W-OVR_OFS]   = ovr[i];
        clr[i]                    = lb_ren;
      end
    end
    if (lb_raddr == SUM_ADDR) rd_word[NUM_CH-1:0] = valid;
    if (lb_raddr == VER_ADDR) rd_word = DATA_W'(VERSION);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb_rdata  <= '0;
      lb_rvalid <= 1'b0;
      lb_wready <= 1'b0;
      irq       <= 1'b0;
    end else begin
      lb_rdata  <= lb_ren ? rd_word : '0;
      lb_rvalid <= lb_ren;
      lb_wready <= 1'b1;
      irq       <= |valid;
    end
  end

endmodule

// File: tb/tb_csr_ro_bank.sv
// Directed scoreboard bench: default bank plus a sticky/non-clearing instance.
module tb_csr_ro_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0, ren1 = 1'b0, ren2 = 1'b0;
  logic [47:0] ch_in = '0;
  logic [3:0]  upd1 = '0, upd2 = '0;
  logic        wready1, wready2, rvalid1, rvalid2, irq1, irq2;
  logic [31:0] rdata1, rdata2;

  int checks = 0;
  int errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  always #5 clk = ~clk;

  csr_ro_bank u_dut1 (
    .clk(clk), .rst(rst), .lb_waddr(waddr), .lb_wdata(wdata), .lb_wen(wen),
    .lb_wready(wready1), .lb_raddr(raddr), .lb_ren(ren1), .lb_rdata(rdata1),
    .lb_rvalid(rvalid1), .ch_in(ch_in), .ch_upd(upd1), .irq(irq1)
  );

  csr_ro_bank #(.STICKY(1'b1), .RCLR(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .lb_waddr(waddr), .lb_wdata(wdata), .lb_wen(wen),
    .lb_wready(wready2), .lb_raddr(raddr), .lb_ren(ren2), .lb_rdata(rdata2),
    .lb_rvalid(rvalid2), .ch_in(ch_in), .ch_upd(upd2), .irq(irq2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int dut, input logic [15:0] a, input logic [31:0] exp);
    raddr = a;
    if (dut == 1) begin ren1 = 1'b1; q1.push_back(exp); end
    else          begin ren2 = 1'b1; q2.push_back(exp); end
    tick();
    ren1 = 1'b0;
    ren2 = 1'b0;
  endtask

  task automatic upd(input int dut, input int ch, input logic [11:0] v);
    ch_in[ch*12 +: 12] = v;
    if (dut == 1) upd1[ch] = 1'b1; else upd2[ch] = 1'b1;
    tick();
    upd1 = '0;
    upd2 = '0;
  endtask

  // Monitors: every rvalid pops one expected word; idle cycles must show 0.
  always @(negedge clk) begin
    if (rst) begin
      if (rvalid1) begin
        if (q1.size() == 0) chk("rd1_unexpected", rdata1, 32'hdeadbeef);
        else chk("rd1", rdata1, q1.pop_front());
      end else chk("rd1_idle", rdata1, 32'h0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (rvalid2) begin
        if (q2.size() == 0) chk("rd2_unexpected", rdata2, 32'hdeadbeef);
        else chk("rd2", rdata2, q2.pop_front());
      end else chk("rd2_idle", rdata2, 32'h0);
    end
  end

  initial begin
    #3;
    chk("rst_rvalid", 32'(rvalid1), 0);
    chk("rst_wready", 32'(wready1), 0);
    chk("rst_irq", 32'(irq1), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("wready_up", 32'(wready1), 1);

    rd(1, 16'h40, 32'h0);
    rd(1, 16'h50, 32'h0);
    rd(1, 16'h54, 32'h00020010);
    rd(1, 16'h60, 32'h0);
    rd(1, 16'h3c, 32'h0);
    chk("irq_idle", 32'(irq1), 0);

    upd(1, 1, 12'habc);
    chk("irq_lag", 32'(irq1), 0);
    tick();
    chk("irq_set", 32'(irq1), 1);
    rd(1, 16'h44, 32'h80000abc);
    rd(1, 16'h44, 32'h0);
    tick();
    chk("irq_clr", 32'(irq1), 0);

    upd(1, 2, 12'h123);
    upd(1, 2, 12'h456);
    rd(1, 16'h50, 32'h4);
    rd(1, 16'h48, 32'hc0000456);
    rd(1, 16'h48, 32'h0);

    // Clearing read and update of ch3 on the same edge.
    upd(1, 3, 12'h001);
    raddr = 16'h4c;
    ren1 = 1'b1;
    q1.push_back(32'h80000001);
    ch_in[36 +: 12] = 12'h7ff;
    upd1[3] = 1'b1;
    tick();
    ren1 = 1'b0;
    upd1 = '0;
    rd(1, 16'h4c, 32'h800007ff);

    upd(1, 1, 12'habc);
    wen = 1'b1; wdata = 32'hffffffff; waddr = 16'h44;
    tick();
    waddr = 16'h54;
    tick();
    wen = 1'b0;
    chk("wready_wr", 32'(wready1), 1);
    rd(1, 16'h44, 32'h80000abc);
    rd(1, 16'h54, 32'h00020010);

    upd(2, 0, 12'h00f);
    upd(2, 0, 12'h0f0);
    rd(2, 16'h40, 32'hc00000ff);
    rd(2, 16'h40, 32'h000000ff);
    upd(2, 0, 12'h001);
    tick();
    chk("irq2_set", 32'(irq2), 1);

    // Async reset while a read response is on the bus.
    raddr = 16'h40;
    ren2 = 1'b1;
    @(posedge clk);
    #1;
    ren2 = 1'b0;
    chk("midrd_rvalid", 32'(rvalid2), 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid2), 0);
    chk("arst_irq", 32'(irq2), 0);
    chk("arst_rdata", rdata2, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
